// File: rtl/int_ctrl_pkg.sv
// Shared types and default parameters for the interrupt controller.
// Imported by int_ctrl and int_prio_enc.
package int_ctrl_pkg;

   localparam int             N_SRC_DEF    = 4;
   localparam int             VEC_W_DEF    = 10;
   localparam logic [9:0]     VEC_BASE_DEF = 10'd1008;
   localparam logic [3:0]     EN_RST_DEF   = 4'b0001;
   localparam int             VEC_STRIDE   = 4;
   localparam int             ID_W         = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: the lowest set index of req wins.
// Purely combinational.
module int_prio_enc
   import int_ctrl_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEF
) (
   input  logic [N_SRC-1:0] req,
   output logic             valid,
   output logic [ID_W-1:0]  idx
);

   // Scan from the top down so the lowest set bit is the final assignment.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Edge-triggered interrupt controller with pending/enable registers,
// fixed priority and a non-nesting IDLE/REQ/SERVICE handshake.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int               N_SRC    = N_SRC_DEF,
   parameter int               VEC_W    = VEC_W_DEF,
   parameter logic [VEC_W-1:0] VEC_BASE = VEC_BASE_DEF,
   parameter logic [N_SRC-1:0] EN_RST   = EN_RST_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_in,
   input  logic             en_we,
   input  logic [N_SRC-1:0] en_in,
   input  logic             clr_we,
   input  logic [N_SRC-1:0] clr_in,
   input  logic             cpu_ack,
   input  logic             s_finish_interr,
   output logic             int_req,
   output logic [VEC_W-1:0] int_vec,
   output logic [ID_W-1:0]  int_id,
   output logic [N_SRC-1:0] pending,
   output logic             in_service
);

   state_t            state, state_d;
   logic [ID_W-1:0]   id_d;
   logic [N_SRC-1:0]  irq_q;
   logic [N_SRC-1:0]  enable;
   logic [N_SRC-1:0]  rise;
   logic [N_SRC-1:0]  sw_clr;
   logic [N_SRC-1:0]  ack_clr;
   logic              win_valid;
   logic [ID_W-1:0]   win_id;

   int_prio_enc #(.N_SRC(N_SRC)) u_prio (
      .req   (pending & enable),
      .valid (win_valid),
      .idx   (win_id)
   );

   assign rise    = irq_in & ~irq_q;
   assign sw_clr  = clr_we ? clr_in : '0;
   assign ack_clr = (state == ST_REQ && cpu_ack) ? (N_SRC'(1) << int_id) : '0;

   // A fresh edge is OR-ed in after the clears so it always survives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_q   <= '0;
         pending <= '0;
         enable  <= EN_RST;
         state   <= ST_IDLE;
         int_id  <= '0;
      end else begin
         irq_q   <= irq_in;
         pending <= (pending & ~(sw_clr | ack_clr)) | rise;
         if (en_we) enable <= en_in;
         state   <= state_d;
         int_id  <= id_d;
      end
   end

   always_comb begin
      state_d = state;
      id_d    = int_id;
      case (state)
         ST_IDLE: begin
            if (win_valid) begin
               state_d = ST_REQ;
               id_d    = win_id;
            end
         end
         ST_REQ:     if (cpu_ack)         state_d = ST_SERVICE;
         ST_SERVICE: if (s_finish_interr) state_d = ST_IDLE;
         default:                         state_d = ST_IDLE;
      endcase
   end

   assign int_req    = (state == ST_REQ);
   assign in_service = (state == ST_SERVICE);
   assign int_vec    = VEC_BASE + VEC_W'(VEC_STRIDE) * VEC_W'(int_id);

endmodule

// File: tb/tb_int_ctrl.sv
// Directed table-driven bench for int_ctrl with a hand-written reset-in-service sequence.
module tb_int_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] irq_in = '0;
   logic       en_we = 1'b0;
   logic [3:0] en_in = '0;
   logic       clr_we = 1'b0;
   logic [3:0] clr_in = '0;
   logic       cpu_ack = 1'b0;
   logic       s_finish_interr = 1'b0;
   logic       int_req;
   logic [9:0] int_vec;
   logic [1:0] int_id;
   logic [3:0] pending;
   logic       in_service;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   int_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .irq_in          (irq_in),
      .en_we           (en_we),
      .en_in           (en_in),
      .clr_we          (clr_we),
      .clr_in          (clr_in),
      .cpu_ack         (cpu_ack),
      .s_finish_interr (s_finish_interr),
      .int_req         (int_req),
      .int_vec         (int_vec),
      .int_id          (int_id),
      .pending         (pending),
      .in_service      (in_service)
   );

   typedef struct {
      logic [3:0] irq;
      logic       en_we;
      logic [3:0] en;
      logic       clr_we;
      logic [3:0] clr;
      logic       ack;
      logic       fin;
      logic       req;
      logic       svc;
      logic [1:0] id;
      logic [9:0] vec;
      logic [3:0] pend;
   } vec_t;

   vec_t tv[$];

   function automatic void add(logic [3:0] irq, logic ewe, logic [3:0] en, logic cwe,
                               logic [3:0] clr, logic ack, logic fin, logic req,
                               logic svc, logic [1:0] id, logic [9:0] vec, logic [3:0] pend);
      vec_t v;
      v = '{irq, ewe, en, cwe, clr, ack, fin, req, svc, id, vec, pend};
      tv.push_back(v);
   endfunction

   task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
      end
   endtask

   task automatic check_outputs(int row, logic req, logic svc, logic [1:0] id,
                                logic [9:0] vec, logic [3:0] pend);
      chk("int_req",    row, 32'(int_req),    32'(req));
      chk("in_service", row, 32'(in_service), 32'(svc));
      chk("int_id",     row, 32'(int_id),     32'(id));
      chk("int_vec",    row, 32'(int_vec),    32'(vec));
      chk("pending",    row, 32'(pending),    32'(pend));
   endtask

   initial begin
      //   irq    ewe en      cwe clr     ack fin  req svc id vec   pend
      add(4'b0000,0,4'b0000,0,4'b0000,0,0, 0,0,0,10'd1008,4'b0000); // 0 idle
      add(4'b0001,0,4'b0000,0,4'b0000,0,0, 0,0,0,10'd1008,4'b0001); // 1 timer edge
      add(4'b0001,0,4'b0000,0,4'b0000,0,0, 1,0,0,10'd1008,4'b0001); // 2 request
      add(4'b0001,0,4'b0000,0,4'b0000,0,0, 1,0,0,10'd1008,4'b0001); // 3 hold
      add(4'b0001,0,4'b0000,0,4'b0000,1,0, 0,1,0,10'd1008,4'b0000); // 4 ack
      add(4'b0001,0,4'b0000,0,4'b0000,1,0, 0,1,0,10'd1008,4'b0000); // 5 ack ignored
      add(4'b0001,0,4'b0000,0,4'b0000,0,1, 0,0,0,10'd1008,4'b0000); // 6 finish
      add(4'b0000,0,4'b0000,0,4'b0000,0,1, 0,0,0,10'd1008,4'b0000); // 7 finish ignored
      add(4'b0000,1,4'b1111,0,4'b0000,0,0, 0,0,0,10'd1008,4'b0000); // 8 enable all
      add(4'b0110,0,4'b0000,0,4'b0000,0,0, 0,0,0,10'd1008,4'b0110); // 9 two edges
      add(4'b0110,0,4'b0000,0,4'b0000,0,0, 1,0,1,10'd1012,4'b0110); // 10 id1 wins
      add(4'b0110,0,4'b0000,0,4'b0000,1,0, 0,1,1,10'd1012,4'b0100); // 11
      add(4'b0110,0,4'b0000,0,4'b0000,0,1, 0,0,1,10'd1012,4'b0100); // 12 idle cycle
      add(4'b0110,0,4'b0000,0,4'b0000,0,0, 1,0,2,10'd1016,4'b0100); // 13 id2
      add(4'b0110,0,4'b0000,0,4'b0000,1,0, 0,1,2,10'd1016,4'b0000); // 14
      add(4'b0000,0,4'b0000,0,4'b0000,0,1, 0,0,2,10'd1016,4'b0000); // 15
      add(4'b0000,1,4'b0001,0,4'b0000,0,0, 0,0,2,10'd1016,4'b0000); // 16 mask to 0001
      add(4'b1000,0,4'b0000,0,4'b0000,0,0, 0,0,2,10'd1016,4'b1000); // 17 masked edge
      add(4'b1000,0,4'b0000,0,4'b0000,0,0, 0,0,2,10'd1016,4'b1000); // 18 stays pending
      add(4'b1000,1,4'b1001,0,4'b0000,0,0, 0,0,2,10'd1016,4'b1000); // 19 unmask
      add(4'b1000,0,4'b0000,0,4'b0000,0,0, 1,0,3,10'd1020,4'b1000); // 20 id3
      add(4'b1000,0,4'b0000,0,4'b0000,1,0, 0,1,3,10'd1020,4'b0000); // 21
      add(4'b0000,0,4'b0000,0,4'b0000,0,1, 0,0,3,10'd1020,4'b0000); // 22
      add(4'b0010,0,4'b0000,1,4'b0010,0,0, 0,0,3,10'd1020,4'b0010); // 23 set beats clr
      add(4'b0010,0,4'b0000,1,4'b0010,0,0, 0,0,3,10'd1020,4'b0000); // 24 clr alone
      add(4'b0011,0,4'b0000,0,4'b0000,0,0, 0,0,3,10'd1020,4'b0001); // 25
      add(4'b0011,0,4'b0000,0,4'b0000,0,0, 1,0,0,10'd1008,4'b0001); // 26
      add(4'b0011,1,4'b0000,0,4'b0000,0,0, 1,0,0,10'd1008,4'b0001); // 27 en write in REQ
      add(4'b0011,0,4'b0000,0,4'b0000,1,0, 0,1,0,10'd1008,4'b0000); // 28
      add(4'b1011,0,4'b0000,0,4'b0000,0,0, 0,1,0,10'd1008,4'b1000); // 29 edge in service
      add(4'b1011,0,4'b0000,0,4'b0000,0,1, 0,0,0,10'd1008,4'b1000); // 30 disabled
      add(4'b1011,1,4'b1111,0,4'b0000,0,0, 0,0,0,10'd1008,4'b1000); // 31
      add(4'b0011,0,4'b0000,0,4'b0000,0,0, 1,0,3,10'd1020,4'b1000); // 32
      add(4'b1011,0,4'b0000,0,4'b0000,1,0, 0,1,3,10'd1020,4'b1000); // 33 set beats ack clr

      // Reset state while reset is held.
      repeat (2) @(posedge clk);
      #1;
      check_outputs(-1, 1'b0, 1'b0, 2'd0, 10'd1008, 4'b0000);
      chk("enable_rst", -1, 32'(dut.enable), 32'(4'b0001));
      reset = 1'b0;

      foreach (tv[i]) begin
         irq_in          = tv[i].irq;
         en_we           = tv[i].en_we;
         en_in           = tv[i].en;
         clr_we          = tv[i].clr_we;
         clr_in          = tv[i].clr;
         cpu_ack         = tv[i].ack;
         s_finish_interr = tv[i].fin;
         @(posedge clk);
         #1;
         check_outputs(i, tv[i].req, tv[i].svc, tv[i].id, tv[i].vec, tv[i].pend);
      end

      // Asynchronous reset while in SERVICE with a pending bit outstanding.
      en_we = 1'b0; clr_we = 1'b0; cpu_ack = 1'b0; s_finish_interr = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check_outputs(100, 1'b0, 1'b0, 2'd0, 10'd1008, 4'b0000);
      chk("enable_async", 100, 32'(dut.enable), 32'(4'b0001));
      irq_in = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_outputs(101, 1'b0, 1'b0, 2'd0, 10'd1008, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
